// File: rtl/instr_encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_ORI = 3'd1,
    OP_SB  = 3'd2,
    OP_ADD = 3'd3,
    OP_AND = 3'd4,
    OP_SLL = 3'd5,
    OP_BNE = 3'd6,
    OP_ILL = 3'd7
  } op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_ORI = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OP    = 2'b01;
  localparam logic [1:0] ERR_IMM   = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write bus of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [2:0]               req_op;
  logic [4:0]               req_rd;
  logic [4:0]               req_rs1;
  logic [4:0]               req_rs2;
  logic signed [12:0]       req_imm;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [31:0]              mem_wdata;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: symbolic op + fields -> 32-bit word, legality and error code.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]         i_op,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic signed [12:0] i_imm,
  output logic [31:0]        o_word,
  output logic               o_legal,
  output logic [1:0]         o_err_code
);

  logic w_imm12_ok;

  // I/S immediates are 12-bit: the 13th bit must be a pure sign extension.
  assign w_imm12_ok = (i_imm[12] == i_imm[11]);

  always_comb begin
    o_word     = '0;
    o_legal    = 1'b1;
    o_err_code = ERR_NONE;
    case (op_e'(i_op))
      OP_LB:  o_word = {i_imm[11:0], i_rs1, F3_LB, i_rd, OPC_LOAD};
      OP_ORI: o_word = {i_imm[11:0], i_rs1, F3_ORI, i_rd, OPC_OPIMM};
      OP_SB:  o_word = {i_imm[11:5], i_rs2, i_rs1, F3_SB, i_imm[4:0], OPC_STORE};
      OP_ADD: o_word = {F7_BASE, i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_AND: o_word = {F7_BASE, i_rs2, i_rs1, F3_AND, i_rd, OPC_OP};
      OP_SLL: o_word = {F7_BASE, i_rs2, i_rs1, F3_SLL, i_rd, OPC_OP};
      OP_BNE: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BNE,
                        i_imm[4:1], i_imm[11], OPC_BRANCH};
      default: begin
        o_legal    = 1'b0;
        o_err_code = ERR_OP;
      end
    endcase

    if ((op_e'(i_op) == OP_LB || op_e'(i_op) == OP_ORI || op_e'(i_op) == OP_SB)
        && !w_imm12_ok) begin
      o_legal    = 1'b0;
      o_err_code = ERR_IMM;
    end
    if (op_e'(i_op) == OP_BNE && i_imm[0]) begin
      o_legal    = 1'b0;
      o_err_code = ERR_ALIGN;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I program writer: accepts symbolic requests and writes packed words
// to consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 64,
  localparam int               CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic              w_write;
  logic              w_legal;
  logic [1:0]        w_code;
  logic [31:0]       w_word;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_last;

  instr_pack u_pack (
    .i_op       (bus.req_op),
    .i_rd       (bus.req_rd),
    .i_rs1      (bus.req_rs1),
    .i_rs2      (bus.req_rs2),
    .i_imm      (bus.req_imm),
    .o_word     (w_word),
    .o_legal    (w_legal),
    .o_err_code (w_code)
  );

  // start wins over a simultaneous request, so that request stays pending.
  assign w_ready    = (r_state == ST_RUN) && !start;
  assign w_accept   = bus.req_valid && w_ready;
  assign w_write    = w_accept && w_legal;
  assign w_cnt_next = r_count + CNT_W'(1);
  assign w_last     = (w_cnt_next == CNT_W'(DEPTH_WORDS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= BASE_ADDR;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_ptr   <= r_ptr + ADDR_W'(4);
        r_count <= w_cnt_next;
        r_full  <= w_last;
        if (w_last) r_state <= ST_FULL;
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_code;
      end
      // A write registered earlier still drains next cycle; only the counters rewind.
      if (start) begin
        r_state    <= ST_RUN;
        r_ptr      <= BASE_ADDR;
        r_count    <= '0;
        r_full     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign count         = r_count;
  assign full          = r_full;
  assign err           = r_err;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder against a field-level encoding model.
module tb_instr_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          DEPTH  = 4;
  localparam int          CNT_W  = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             err;
  logic [1:0]       err_code;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          m_run;
  int          m_cnt;
  bit          m_err;
  int          m_ec;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit layout taken field by field from the RV32I formats.
  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input int imm);
    logic [31:0] w;
    logic [31:0] u;
    u = imm;
    w = (rs1 << 15);
    case (op)
      0: w = w | ((u & 32'hFFF) << 20) | (rd << 7) | 32'h03;
      1: w = w | ((u & 32'hFFF) << 20) | (6 << 12) | (rd << 7) | 32'h13;
      2: w = w | (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((u & 32'h1F) << 7) | 32'h23;
      3: w = w | (rs2 << 20) | (rd << 7) | 32'h33;
      4: w = w | (rs2 << 20) | (7 << 12) | (rd << 7) | 32'h33;
      5: w = w | (rs2 << 20) | (1 << 12) | (rd << 7) | 32'h33;
      default: w = w | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (1 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
    endcase
    return w;
  endfunction

  function automatic int ref_code(input int op, input int imm);
    if (op == 7) return 1;
    if (op <= 2 && (imm < -2048 || imm > 2047)) return 2;
    if (op == 6 && (imm % 2) != 0) return 3;
    return 0;
  endfunction

  function automatic void model_reset();
    m_run   = 1'b0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_ec    = 0;
    m_we    = 1'b0;
    m_addr  = BASE;
    m_wdata = 32'h0;
  endfunction

  task automatic check_outputs(input string pfx);
    check_val({pfx, "_we"},    32'(bus.mem_we),   32'(m_we));
    check_val({pfx, "_addr"},  bus.mem_addr,      m_addr);
    check_val({pfx, "_wdata"}, bus.mem_wdata,     m_wdata);
    check_val({pfx, "_count"}, 32'(count),        32'(m_cnt));
    check_val({pfx, "_full"},  32'(full),         32'(m_cnt == DEPTH));
    check_val({pfx, "_err"},   32'(err),          32'(m_err));
    check_val({pfx, "_ecode"}, 32'(err_code),     32'(m_ec));
  endtask

  task automatic drive_inputs(input bit v, input int op, input int rd, input int rs1,
                              input int rs2, input int imm, input bit st);
    logic [31:0] iv;
    iv = imm;
    bus.req_valid = v;
    bus.req_op    = 3'(op);
    bus.req_rd    = 5'(rd);
    bus.req_rs1   = 5'(rs1);
    bus.req_rs2   = 5'(rs2);
    bus.req_imm   = iv[12:0];
    start         = st;
  endtask

  task automatic step(input bit v, input int op, input int rd, input int rs1,
                      input int rs2, input int imm, input bit st);
    bit exp_ready;
    int code;
    @(negedge clock);
    drive_inputs(v, op, rd, rs1, rs2, imm, st);
    #1;
    exp_ready = m_run && !st;
    check_val("ready", 32'(bus.req_ready), 32'(exp_ready));
    m_we = 1'b0;
    if (v && exp_ready) begin
      code = ref_code(op, imm);
      if (code == 0) begin
        m_we    = 1'b1;
        m_addr  = BASE + 32'(4 * m_cnt);
        m_wdata = ref_word(op, rd, rs1, rs2, imm);
        m_cnt++;
        if (m_cnt == DEPTH) m_run = 1'b0;
      end else begin
        if (!m_err) m_ec = code;
        m_err = 1'b1;
      end
    end
    if (st) begin
      m_run = 1'b1;
      m_cnt = 0;
      m_err = 1'b0;
      m_ec  = 0;
    end
    @(posedge clock);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle_start();
    step(1'b0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    check_val("rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clock);
    drive_inputs(1'b0, 0, 0, 0, 0, 0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_inputs(1'b0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("por");
    check_val("por_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;

    // IDLE ignores requests until start
    step(1'b1, 3, 3, 1, 2, 0, 1'b0);
    idle_start();
    step(1'b1, 3, 3, 1, 2, 0, 1'b0);
    check_val("add_word", bus.mem_wdata, 32'h002081B3);
    check_val("add_addr", bus.mem_addr, 32'h0);

    idle_start();
    step(1'b1, 0, 5, 6, 0, -4, 1'b0);
    check_val("lb_word", bus.mem_wdata, 32'hFFC30283);
    step(1'b1, 2, 0, 2, 7, 5, 1'b0);
    check_val("sb_word", bus.mem_wdata, 32'h007102A3);
    check_val("sb_addr", bus.mem_addr, 32'h4);
    step(1'b1, 1, 1, 0, 0, -1, 1'b0);
    check_val("ori_word", bus.mem_wdata, 32'hFFF06093);
    check_val("ori_addr", bus.mem_addr, 32'h8);

    idle_start();
    step(1'b1, 6, 0, 1, 2, -8, 1'b0);
    check_val("bne_word", bus.mem_wdata, 32'hFE209CE3);
    step(1'b1, 6, 0, 1, 2, 7, 1'b0);
    check_val("bne_odd_code", 32'(err_code), 32'h3);
    step(1'b1, 7, 0, 0, 0, 0, 1'b0);
    check_val("sticky_code", 32'(err_code), 32'h3);

    idle_start();
    step(1'b1, 1, 1, 0, 0, 2048, 1'b0);
    check_val("imm_code", 32'(err_code), 32'h2);
    step(1'b1, 4, 1, 1, 1, 0, 1'b0);
    check_val("and_word", bus.mem_wdata, 32'h0010F0B3);
    check_val("and_addr", bus.mem_addr, 32'h0);

    // fill to capacity, then a held fifth request
    idle_start();
    for (int i = 0; i < 5; i++) step(1'b1, 3, i + 1, 1, 2, 0, 1'b0);
    check_val("cap_full", 32'(full), 32'h1);
    check_val("cap_last_addr", bus.mem_addr, 32'hC);
    step(1'b1, 3, 9, 1, 2, 0, 1'b1);
    check_val("restart_count", 32'(count), 32'h0);
    step(1'b1, 3, 9, 1, 2, 0, 1'b0);
    check_val("restart_addr", bus.mem_addr, 32'h0);

    // start while the previous write is draining
    step(1'b1, 3, 4, 1, 2, 0, 1'b0);
    idle_start();

    // reset the cycle after an acceptance drops the write
    @(negedge clock);
    drive_inputs(1'b1, 3, 3, 1, 2, 0, 1'b0);
    @(posedge clock);
    #1;
    pulse_reset();
    step(1'b1, 3, 3, 1, 2, 0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      int op, imm;
      bit v, st;
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 19) == 0);
      op  = $urandom_range(0, 7);
      imm = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4095)) - 2048
                                         : int'($urandom_range(0, 8191)) - 4096;
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clock);
        #2;
        pulse_reset();
      end else begin
        step(v, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             imm, st);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder and program writer: the inverse of the control/decode path. It accepts symbolic operation requests (LB, ORI, SB, ADD, AND, SLL, BNE) with register and immediate fields over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them to consecutive instruction-memory addresses. It is used to load test programs into the datapath's instruction memory.

## Interface
Parameters:
- ADDR_W, 32, width of mem_addr.
- BASE_ADDR, 0, byte address of the first written word.
- DEPTH_WORDS, 64, program capacity in words (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; rewinds to BASE_ADDR, clears count/err, enters RUN.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready at a rising edge.
- req_op  in  3  0 LB, 1 ORI, 2 SB, 3 ADD, 4 AND, 5 SLL, 6 BNE, 7 illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  13  signed immediate (byte offset for BNE).
- mem_we  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_W  byte address of the word.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH_WORDS)+1  words written since start.
- full  out  1  count == DEPTH_WORDS.
- err  out  1  sticky error flag.
- err_code  out  2  first error: 01 illegal op, 10 imm out of 12-bit range, 11 BNE odd offset.

## Operation
- States: IDLE (after reset), RUN, FULL. IDLE→RUN on start; RUN→FULL when the write making count==DEPTH_WORDS is issued; FULL→RUN on start; start from RUN restarts in place.
- req_ready = (state==RUN) && !start. start has priority over a simultaneous request; that request is not accepted.
- Encoding (opcode/funct3/funct7): LB 0000011/000 I-type; ORI 0010011/110 I-type; SB 0100011/000 S-type; ADD 0110011/000/0000000; AND 0110011/111/0000000; SLL 0110011/001/0000000; BNE 1100011/001 B-type, with imm[12|10:5] in bits 31:25 and imm[4:1|11] in bits 11:7.
- Unused fields are zero: rs2 for I-type, rd for S/B-type.
- Legality: for I- and S-type ops, req_imm[12] must equal req_imm[11]. For BNE, req_imm[0] must be 0. op 7 is illegal.
- Illegal requests are consumed: the handshake completes, no write is issued, count is unchanged, err is set, and err_code latches only if err was 0.
- Address: the internal pointer starts at BASE_ADDR and advances by 4 per write. Addresses do not wrap; no write is issued beyond BASE_ADDR+4*(DEPTH_WORDS-1).

## Timing
- A request accepted at edge N produces mem_we=1 in cycle N+1, with mem_addr and mem_wdata registered at edge N. Throughput is one word per cycle.
- count and full update at the same edge as mem_we rises.
- mem_we is deasserted in every cycle without an accepted legal request. mem_addr and mem_wdata hold their last values.
- Reset values: mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, full 0, err 0, err_code 00, req_ready 0, state IDLE.
- Reset asserted mid-stream drops any pending write; no mem_we is issued after reset.
- A start in the same cycle that a write is registered lets that write complete (mem_we in the next cycle). Counters rewind after that write.

## Structure
- Package instr_encoder_pkg holds:
  - the op enum (3 bits);
  - the opcode, funct3 and funct7 localparams;
  - the state enum;
  - the err_code constants.
- Sub-module instr_pack: combinational. It takes op/rd/rs1/rs2/imm and produces word, legal and err_code. Instantiate it once, in front of the output register.

## Test plan
- After reset, then start: ADD rd=3 rs1=1 rs2=2 → mem_we one cycle later, mem_addr=0, mem_wdata=0x002081B3, count=1.
- Back-to-back: LB rd=5 rs1=6 imm=-4, then SB rs1=2 rs2=7 imm=5, then ORI rd=1 rs1=0 imm=-1 → words 0xFFC30283, 0x007102A3, 0xFFF06093 at addresses 0, 4, 8 in consecutive cycles.
- BNE rs1=1 rs2=2 imm=-8 → 0xFE209CE3. BNE imm=7 → no write, err=1, err_code=11. A later op=7 → err_code stays 11.
- ORI imm=2048 → no write, err_code=10. A following AND rd=1 rs1=1 rs2=1 still writes 0x0010F0B3 at the next address.
- DEPTH_WORDS=4, five valid requests → writes at 0, 4, 8, 12; full=1; req_ready=0 with the 5th request held. start → count=0, next write at address 0.
- Reset asserted the cycle after acceptance → no mem_we, all outputs at reset values, req_ready=0 until start.
